// File: rtl/clk_div_pkg.sv
// Shared types and configuration helpers for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned clamp_div(input int unsigned n);
    return (n < MIN_DIV) ? MIN_DIV : n;
  endfunction

  // n must already be a legal period; result always lies in 1..n-1.
  function automatic int unsigned clamp_hi(input int unsigned n, input int unsigned h);
    if (h == 0)
      return 1;
    else if (h >= n)
      return n - 1;
    else
      return h;
  endfunction

  function automatic int unsigned half_hi(input int unsigned n);
    return n / 2;
  endfunction

endpackage

// File: rtl/clk_div_cfg_shadow.sv
// Shadow/active configuration registers with clamping and boundary transfer.
// CLK_DIV_PROG_DUTY_EN: when defined cfg_hi_i is honoured, otherwise H = floor(N/2).
module clk_div_cfg_shadow
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 5,
  parameter int unsigned DEF_HI  = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cfg_load_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  input  logic [CNT_W-1:0] cfg_hi_i,
  input  logic             xfer_i,
  output logic [CNT_W-1:0] div_act_o,
  output logic [CNT_W-1:0] hi_nxt_o,
  output logic             cfg_pend_o
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(clamp_div(DEF_DIV));
`ifdef CLK_DIV_PROG_DUTY_EN
  localparam logic [CNT_W-1:0] RST_HI  = CNT_W'(clamp_hi(clamp_div(DEF_DIV), DEF_HI));
`else
  localparam logic [CNT_W-1:0] RST_HI  = CNT_W'(half_hi(clamp_div(DEF_DIV)));
  localparam int unsigned      unused_def_hi = DEF_HI;
  logic unused_cfg_hi;
  assign unused_cfg_hi = ^cfg_hi_i;
`endif

  logic [CNT_W-1:0] cap_div, cap_hi;
  logic [CNT_W-1:0] sh_div_q, sh_div_d;
  logic [CNT_W-1:0] sh_hi_q, sh_hi_d;
  logic [CNT_W-1:0] act_div_q, act_div_d;
  logic [CNT_W-1:0] act_hi_q, act_hi_d;
  logic             pend_q, pend_d;

  always_comb begin
    cap_div = CNT_W'(clamp_div(32'(cfg_div_i)));
`ifdef CLK_DIV_PROG_DUTY_EN
    cap_hi  = CNT_W'(clamp_hi(32'(cap_div), 32'(cfg_hi_i)));
`else
    cap_hi  = CNT_W'(half_hi(32'(cap_div)));
`endif
  end

  // A load on the transfer edge bypasses the shadow so it governs the new period.
  always_comb begin
    sh_div_d  = sh_div_q;
    sh_hi_d   = sh_hi_q;
    act_div_d = act_div_q;
    act_hi_d  = act_hi_q;
    pend_d    = pend_q;
    if (cfg_load_i) begin
      sh_div_d = cap_div;
      sh_hi_d  = cap_hi;
    end
    if (xfer_i) begin
      act_div_d = cfg_load_i ? cap_div : sh_div_q;
      act_hi_d  = cfg_load_i ? cap_hi  : sh_hi_q;
      pend_d    = 1'b0;
    end else if (cfg_load_i) begin
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sh_div_q  <= RST_DIV;
      sh_hi_q   <= RST_HI;
      act_div_q <= RST_DIV;
      act_hi_q  <= RST_HI;
      pend_q    <= 1'b0;
    end else begin
      sh_div_q  <= sh_div_d;
      sh_hi_q   <= sh_hi_d;
      act_div_q <= act_div_d;
      act_hi_q  <= act_hi_d;
      pend_q    <= pend_d;
    end
  end

  assign div_act_o  = act_div_q;
  assign hi_nxt_o   = act_hi_d;
  assign cfg_pend_o = pend_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free start/stop.
// CLK_DIV_PROG_DUTY_EN selects programmable high time (default: 50% floor).
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 5,
  parameter int unsigned DEF_HI  = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_hi,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             cfg_pend,
  output logic             running
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             xfer;
  logic             cnt_last;
  logic [CNT_W-1:0] div_act, hi_nxt;

  clk_div_cfg_shadow #(
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV),
    .DEF_HI  (DEF_HI)
  ) u_shadow (
    .clk_in     (clk_in),
    .rst        (rst),
    .cfg_load_i (cfg_load),
    .cfg_div_i  (cfg_div),
    .cfg_hi_i   (cfg_hi),
    .xfer_i     (xfer),
    .div_act_o  (div_act),
    .hi_nxt_o   (hi_nxt),
    .cfg_pend_o (cfg_pend)
  );

  assign cnt_last = (cnt_q == div_act - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xfer    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d = RUN;
          xfer    = 1'b1;
        end
      end
      RUN: begin
        cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
        xfer  = cnt_last;
        if (!en)
          state_d = STOPPING;
      end
      STOPPING: begin
        cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
        if (en) begin
          state_d = RUN;
          xfer    = cnt_last;
        end else if (cnt_last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output level follows the next count against the high time of the period it belongs to.
  always_comb begin
    clk_d  = (state_d != IDLE) && (cnt_d < hi_nxt);
    rise_d = clk_d & ~clk_q;
    fall_d = ~clk_d & clk_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clk_out   = clk_q;
  assign tick_rise = rise_q;
  assign tick_fall = fall_q;
  assign running   = (state_q != IDLE);

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: stimulus queues per-cycle expectations, a monitor checks them.
module tb_clk_div_prog;

`ifdef CLK_DIV_PROG_DUTY_EN
  localparam int H8 = 3, H10 = 9, H6 = 1, H7 = 1;
`else
  localparam int H8 = 4, H10 = 5, H6 = 3, H7 = 3;
`endif

  logic       clk_in = 1'b0;
  logic       rst, en, cfg_load;
  logic [7:0] cfg_div, cfg_hi;
  logic       clk_out, tick_rise, tick_fall, cfg_pend, running;

  typedef struct {
    logic [4:0] v;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  clk_div_prog #(
    .CNT_W   (8),
    .DEF_DIV (5),
    .DEF_HI  (2)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .cfg_load  (cfg_load),
    .cfg_div   (cfg_div),
    .cfg_hi    (cfg_hi),
    .clk_out   (clk_out),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall),
    .cfg_pend  (cfg_pend),
    .running   (running)
  );

  always #5 clk_in = ~clk_in;

  // Monitor: one expectation per clock, fields {clk_out,tick_rise,tick_fall,cfg_pend,running}.
  initial begin : monitor
    forever begin : mon_loop
      exp_t       e;
      logic [4:0] act;
      @(negedge clk_in);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {clk_out, tick_rise, tick_fall, cfg_pend, running};
        n_chk++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s @%0t: got co/tr/tf/pend/run=%b expected %b", e.nm, $time, act, e.v);
        end
      end
    end
  end

  task automatic tick(input bit co, input bit tr, input bit tf, input bit pd, input bit rn,
                      input string nm);
    exp_t e;
    @(posedge clk_in);
    e.v  = {co, tr, tf, pd, rn};
    e.nm = nm;
    exp_q.push_back(e);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic per(input int h, input int n, input string nm);
    for (int i = 0; i < n; i++)
      tick(i < h, i == 0, i == h, 1'b0, 1'b1, nm);
  endtask

  // One period of h/n with a load issued at cycle ld (ld=0 coincides with the boundary).
  task automatic per_ld(input int h, input int n, input int ld, input logic [7:0] d,
                        input logic [7:0] hh, input string nm);
    for (int i = 0; i < n; i++) begin
      if (i == ld) begin
        cfg_load = 1'b1;
        cfg_div  = d;
        cfg_hi   = hh;
      end
      tick(i < h, i == 0, i == h, (ld > 0) && (i >= ld), 1'b1, nm);
    end
  endtask

  initial begin : stim
    rst = 1'b1; en = 1'b0; cfg_load = 1'b0; cfg_div = '0; cfg_hi = '0;
    tick(0, 0, 0, 0, 0, "reset");
    tick(0, 0, 0, 0, 0, "reset");
    rst = 1'b0;
    tick(0, 0, 0, 0, 0, "idle");

    en = 1'b1;
    repeat (3) per(2, 5, "default_5_2");

    per_ld(2, 5, 3, 8'd8, 8'd3, "load_mid_8_3");
    repeat (2) per(H8, 8, "after_8_3");

    per_ld(H8, 8, 1, 8'd1, 8'd0, "load_clamp_1_0");
    repeat (3) per(1, 2, "clamped_2_1");
    per_ld(1, 2, 1, 8'd10, 8'd12, "load_clamp_10_12");
    per(H10, 10, "clamped_10");

    per_ld(H6, 6, 0, 8'd6, 8'd1, "bypass_6_1");
    per(H6, 6, "after_bypass_6");

    per_ld(2, 5, 0, 8'd5, 8'd2, "bypass_5_2");
    tick(1, 1, 0, 0, 1, "stop_c0");
    tick(1, 0, 0, 0, 1, "stop_c1");
    en = 1'b0;
    tick(0, 0, 1, 0, 1, "stop_c2");
    tick(0, 0, 0, 0, 1, "stop_c3");
    tick(0, 0, 0, 0, 1, "stop_c4");
    tick(0, 0, 0, 0, 0, "stopped_idle");
    tick(0, 0, 0, 0, 0, "stopped_idle");

    en = 1'b1;
    per(2, 5, "restart");
    tick(1, 1, 0, 0, 1, "resume_c0");
    tick(1, 0, 0, 0, 1, "resume_c1");
    en = 1'b0;
    tick(0, 0, 1, 0, 1, "resume_c2");
    tick(0, 0, 0, 0, 1, "resume_c3");
    en = 1'b1;
    tick(0, 0, 0, 0, 1, "resume_c4");
    per(2, 5, "resumed");

    per_ld(H8, 8, 0, 8'd8, 8'd3, "bypass_8_3");
    tick(1, 1, 0, 0, 1, "pre_rst_c0");
    cfg_load = 1'b1; cfg_div = 8'd3; cfg_hi = 8'd1;
    tick(1, 0, 0, 1, 1, "pre_rst_c1");
    rst = 1'b1;
    tick(0, 0, 0, 0, 0, "rst_mid");
    rst = 1'b0;
    repeat (2) per(2, 5, "post_rst_5_2");

    per_ld(H7, 7, 0, 8'd7, 8'd1, "bypass_7_1");
    per(H7, 7, "after_7_1");

    en = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk_in);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
